ahb_slave_port_mux: RTL

Slave-side address/data multiplexer that consumes the registered one-hot grant from a per-slave arbiter (AHB_arbiter_slave_N).
- Routes the granted master's address-phase signals to the slave.
- Tracks data-phase ownership across wait states and routes write data to the slave.
- Routes hready/hresp/hrdata back to masters and returns a wait indication to the arbiter.
One instance per slave port in the generated interconnect.

---
 rtl/ahb_slave_port_mux_pkg.sv | 34 +++
 rtl/ahb_slave_port_mux_onehot_mux.sv | 19 +
 rtl/ahb_slave_port_mux.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ahb_slave_port_mux_pkg.sv
// Shared AHB types and constants for the slave-port multiplexer.
package ahb_slave_port_mux_pkg;

  localparam int unsigned HBURST_W = 3;

  typedef enum logic [HBURST_W-1:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_type;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } mux_state_type;

endpackage

// File: rtl/ahb_slave_port_mux_onehot_mux.sv
// Generic AND-OR multiplexer selected by a one-hot (or all-zero) vector.
module onehot_mux #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] din,
  output logic [W-1:0]        dout
);

  // OR together every input whose select bit is set; all-zero select yields 0
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < N; i++) begin
      dout = dout | (din[i] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/ahb_slave_port_mux.sv
// AHB slave-port multiplexer: routes the granted master's address phase to
// the slave, tracks data-phase ownership across wait states, and returns
// ready/response/read data to the masters.
// Optional: AHB_SLAVE_MUX_ERROR_CANCEL_EN forces s_htrans to IDLE during the
// second ERROR cycle, cancelling the erroring master's pipelined transfer.
module ahb_slave_port_mux
  import ahb_slave_port_mux_pkg::*;
#(
  parameter int unsigned MASTER_NUM = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                  hclk,
  input  logic                                  hreset_n,
  input  logic [MASTER_NUM-1:0]                 grant,
  input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_haddr,
  input  logic [MASTER_NUM-1:0][1:0]            m_htrans,
  input  logic [MASTER_NUM-1:0]                 m_hwrite,
  input  logic [MASTER_NUM-1:0][2:0]            m_hsize,
  input  hburst_type [MASTER_NUM-1:0]           m_hburst,
  input  logic [MASTER_NUM-1:0][DATA_WIDTH-1:0] m_hwdata,
  output logic                                  s_hsel,
  output logic [ADDR_WIDTH-1:0]                 s_haddr,
  output logic [1:0]                            s_htrans,
  output logic                                  s_hwrite,
  output logic [2:0]                            s_hsize,
  output hburst_type                            s_hburst,
  output logic [DATA_WIDTH-1:0]                 s_hwdata,
  input  logic                                  s_hreadyout,
  input  logic                                  s_hresp,
  input  logic [DATA_WIDTH-1:0]                 s_hrdata,
  output logic [MASTER_NUM-1:0]                 m_hready,
  output logic [MASTER_NUM-1:0]                 m_hresp,
  output logic [DATA_WIDTH-1:0]                 m_hrdata,
  output logic                                  hwait
);

  localparam int unsigned CTRL_W = 1 + 3 + HBURST_W + 2;

  mux_state_type               state;
  logic [MASTER_NUM-1:0]       dp_owner;
  logic                        dp_write;
  logic [MASTER_NUM-1:0][CTRL_W-1:0] m_ctrl;
  logic [CTRL_W-1:0]           s_ctrl;
  logic [1:0]                  mux_htrans;
  logic                        accept;

  // Pack per-master control fields so one mux instance serves them all
  always_comb begin
    m_ctrl = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      m_ctrl[i] = {m_hwrite[i], m_hsize[i], m_hburst[i], m_htrans[i]};
    end
  end

  onehot_mux #(.W(ADDR_WIDTH), .N(MASTER_NUM)) u_addr_mux (
    .sel (grant),
    .din (m_haddr),
    .dout(s_haddr)
  );

  onehot_mux #(.W(CTRL_W), .N(MASTER_NUM)) u_ctrl_mux (
    .sel (grant),
    .din (m_ctrl),
    .dout(s_ctrl)
  );

  onehot_mux #(.W(DATA_WIDTH), .N(MASTER_NUM)) u_wdata_mux (
    .sel (dp_owner),
    .din (m_hwdata),
    .dout(s_hwdata)
  );

  assign s_hsel     = |grant;
  assign s_hwrite   = s_ctrl[CTRL_W-1];
  assign s_hsize    = s_ctrl[CTRL_W-2 -: 3];
  assign s_hburst   = hburst_type'(s_ctrl[2 +: HBURST_W]);
  assign mux_htrans = s_ctrl[1:0];

`ifdef AHB_SLAVE_MUX_ERROR_CANCEL_EN
  // Forcing IDLE here also keeps dp_owner from loading at the ERR1 accept
  assign s_htrans = (state == ST_ERR1) ? HTRANS_IDLE : mux_htrans;
`else
  assign s_htrans = mux_htrans;
`endif

  assign accept   = s_hreadyout & s_hsel & s_htrans[1];
  assign m_hrdata = s_hrdata;
  assign hwait    = (|dp_owner) & ~s_hreadyout;

  // Return ready to requesters and data-phase owner; response only to owner
  always_comb begin
    m_hready = '0;
    m_hresp  = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      m_hready[i] = (grant[i] | dp_owner[i]) ? s_hreadyout : 1'b0;
      m_hresp[i]  = dp_owner[i] ? s_hresp : HRESP_OKAY;
    end
  end

  // Data-phase ownership and error-sequence state machine
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state    <= ST_IDLE;
      dp_owner <= '0;
      dp_write <= 1'b0;
    end else begin
      if (s_hreadyout) begin
        dp_owner <= accept ? grant : '0;
        dp_write <= accept & s_hwrite;
      end
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_DATA;
        end
        ST_DATA: begin
          if ((s_hresp == HRESP_ERROR) && !s_hreadyout) state <= ST_ERR1;
          else if (s_hreadyout)                        state <= accept ? ST_DATA : ST_IDLE;
        end
        ST_ERR1: begin
          if (s_hreadyout) state <= ST_ERR2;
        end
        ST_ERR2: begin
          if ((|dp_owner) && (s_hresp == HRESP_ERROR) && !s_hreadyout) state <= ST_ERR1;
          else if (s_hreadyout)                                        state <= accept ? ST_DATA : ST_IDLE;
          else                                                         state <= (|dp_owner) ? ST_DATA : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_err_two_cycle: assert property (@(posedge hclk) disable iff (!hreset_n)
    ((|dp_owner) && (s_hresp == HRESP_ERROR) && s_hreadyout) |-> (state == ST_ERR1));

  a_write_has_owner: assert property (@(posedge hclk) disable iff (!hreset_n)
    dp_write |-> (|dp_owner));

  a_grant_onehot0: assert property (@(posedge hclk) disable iff (!hreset_n)
    $onehot0(grant));

endmodule
